// File: rtl/tetris_pkg.sv
// Board geometry and lock/clear FSM encoding shared by the playfield blocks.
package tetris_pkg;

    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 24;
    localparam int COLOUR_W = 6;

    localparam logic [COLOUR_W-1:0] EMPTY = '0;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SCAN,
        SHIFT,
        DONE
    } lock_state_e;

endpackage

// File: rtl/board_addr.sv
// Linear board address y*BOARD_W + x, formed at 9 bits and truncated to the 8-bit RAM address.
module board_addr
    import tetris_pkg::*;
(
    input  logic [4:0] x,
    input  logic [5:0] y,
    output logic [7:0] addr
);

    assign addr = 8'({3'b000, y} * 9'(BOARD_W) + {4'b0000, x});

endmodule

// File: rtl/lut.sv
// Tetromino geometry: four (x,y) offsets packed two bits per cell plus the piece colour.
module lut
    import tetris_pkg::*;
(
    input  logic [3:0]          block,
    input  logic [1:0]          rot,
    output logic [7:0]          coord_x,
    output logic [7:0]          coord_y,
    output logic [COLOUR_W-1:0] colour
);

    // Cell i lives in bits [2i+1:2i]; literals below list cell 3 first.
    always_comb begin
        coord_x = 8'b01_00_01_00;
        coord_y = 8'b01_01_00_00;
        colour  = COLOUR_W'(2);
        case ({rot, block})
            6'h00: begin coord_x = 8'b11_10_01_00; coord_y = 8'b00_00_00_00; colour = COLOUR_W'(1); end
            6'h01: begin coord_x = 8'b01_00_01_00; coord_y = 8'b01_01_00_00; colour = COLOUR_W'(2); end
            6'h02: begin coord_x = 8'b01_10_01_00; coord_y = 8'b01_00_00_00; colour = COLOUR_W'(3); end
            6'h03: begin coord_x = 8'b01_00_10_01; coord_y = 8'b01_01_00_00; colour = COLOUR_W'(4); end
            6'h04: begin coord_x = 8'b10_01_01_00; coord_y = 8'b01_01_00_00; colour = COLOUR_W'(5); end
            6'h05: begin coord_x = 8'b10_01_00_00; coord_y = 8'b01_01_01_00; colour = COLOUR_W'(6); end
            6'h06: begin coord_x = 8'b10_01_00_10; coord_y = 8'b01_01_01_00; colour = COLOUR_W'(7); end
            6'h08: begin coord_x = 8'b00_00_00_00; coord_y = 8'b11_10_01_00; colour = COLOUR_W'(1); end
            default: ;
        endcase
    end

endmodule

// File: rtl/piece_lock_clear.sv
// Writes a landed piece into board RAM, then removes full rows bottom-up by shifting the board down.
module piece_lock_clear
    import tetris_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [4:0]          X_anchor,
    input  logic [5:0]          Y_anchor,
    input  logic [3:0]          block,
    input  logic [COLOUR_W-1:0] ram_Q,
    output logic [7:0]          ram_addr,
    output logic [COLOUR_W-1:0] ram_data,
    output logic                ram_wren,
    output logic                busy,
    output logic                done,
    output logic [2:0]          lines_cleared,
    output logic                cell_dropped
);

    lock_state_e         state_q, state_d;
    logic [4:0]          x_q, x_d;
    logic [5:0]          y_q, y_d;
    logic [3:0]          blk_q, blk_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [4:0]          row_q, row_d;
    logic [4:0]          dst_q, dst_d;
    logic [3:0]          col_q, col_d;
    logic                phase_q, phase_d;
    logic                full_q, full_d;
    logic [2:0]          lines_q, lines_d;
    logic                dropped_q, dropped_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          addr_q, addr_d;
    logic [COLOUR_W-1:0] data_q, data_d;
    logic                wren_q, wren_d;
    logic                copy_q, copy_d;

    logic [7:0]          coord_x, coord_y;
    logic [COLOUR_W-1:0] colour;
    logic [1:0]          cx, cy;
    logic [5:0]          cell_x;
    logic [6:0]          cell_y;
    logic                cell_ok;
    logic [4:0]          ax;
    logic [5:0]          ay;
    logic [7:0]          addr_calc;
    logic                last_ok;

    lut u_lut (
        .block   (blk_q),
        .rot     (2'b00),
        .coord_x (coord_x),
        .coord_y (coord_y),
        .colour  (colour)
    );

    board_addr u_board_addr (
        .x    (ax),
        .y    (ay),
        .addr (addr_calc)
    );

    assign cx      = coord_x[{idx_q, 1'b0} +: 2];
    assign cy      = coord_y[{idx_q, 1'b0} +: 2];
    assign cell_x  = {1'b0, x_q} + {4'b0000, cx};
    assign cell_y  = {1'b0, y_q} + {5'b00000, cy};
    assign cell_ok = (cell_x < 6'(BOARD_W)) && (cell_y < 7'(BOARD_H));
    assign last_ok = full_q && (ram_Q != EMPTY);

    always_comb begin
        ax = {1'b0, col_q};
        ay = {1'b0, dst_q};
        case (state_q)
            WRITE: begin ax = cell_x[4:0]; ay = cell_y[5:0]; end
            SCAN:  begin ax = {1'b0, cnt_q}; ay = {1'b0, row_q}; end
            SHIFT: if (!phase_q && dst_q != 5'd0) ay = {1'b0, dst_q - 5'd1};
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        blk_d     = blk_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        dst_d     = dst_q;
        col_d     = col_q;
        phase_d   = phase_q;
        full_d    = full_q;
        lines_d   = lines_q;
        dropped_d = dropped_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        copy_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d   = WRITE;
                    x_d       = X_anchor;
                    y_d       = Y_anchor;
                    blk_d     = block;
                    idx_d     = 2'd0;
                    lines_d   = 3'd0;
                    dropped_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            WRITE: begin
                if (cell_ok) begin
                    wren_d = 1'b1;
                    addr_d = addr_calc;
                    data_d = colour;
                end else begin
                    dropped_d = 1'b1;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = SCAN;
                    row_d   = 5'(BOARD_H - 1);
                    cnt_d   = 4'd0;
                    full_d  = 1'b1;
                end
            end
            SCAN: begin
                // Read data trails the issued address by two cycles through the output register and RAM.
                if (cnt_q < 4'(BOARD_W)) addr_d = addr_calc;
                if (cnt_q >= 4'd2) full_d = last_ok;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(BOARD_W + 1)) begin
                    cnt_d  = 4'd0;
                    full_d = 1'b1;
                    if (last_ok) begin
                        state_d = SHIFT;
                        lines_d = (lines_q == 3'd4) ? lines_q : lines_q + 3'd1;
                        dst_d   = row_q;
                        col_d   = 4'd0;
                        phase_d = 1'b0;
                    end else if (row_q == 5'd0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q - 5'd1;
                    end
                end
            end
            SHIFT: begin
                addr_d = addr_calc;
                if (dst_q == 5'd0) begin
                    wren_d = 1'b1;
                    data_d = EMPTY;
                    col_d  = col_q + 4'd1;
                    if (col_q == 4'(BOARD_W - 1)) begin
                        state_d = SCAN;
                        col_d   = 4'd0;
                        cnt_d   = 4'd0;
                        full_d  = 1'b1;
                    end
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    // Source cell arrives on ram_Q in the same cycle the destination is addressed.
                    wren_d  = 1'b1;
                    copy_d  = 1'b1;
                    phase_d = 1'b0;
                    col_d   = col_q + 4'd1;
                    if (col_q == 4'(BOARD_W - 1)) begin
                        col_d = 4'd0;
                        dst_d = dst_q - 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            blk_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            row_q     <= '0;
            dst_q     <= '0;
            col_q     <= '0;
            phase_q   <= 1'b0;
            full_q    <= 1'b0;
            lines_q   <= '0;
            dropped_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            copy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            blk_q     <= blk_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            dst_q     <= dst_d;
            col_q     <= col_d;
            phase_q   <= phase_d;
            full_q    <= full_d;
            lines_q   <= lines_d;
            dropped_q <= dropped_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            copy_q    <= copy_d;
        end
    end

    assign ram_addr      = addr_q;
    assign ram_data      = copy_q ? ram_Q : data_q;
    assign ram_wren      = wren_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign cell_dropped  = dropped_q;

endmodule

// File: tb/tb_piece_lock_clear.sv
// Directed bench for piece_lock_clear against a behavioural single-port board RAM.
module tb_piece_lock_clear;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [4:0] X_anchor = '0;
    logic [5:0] Y_anchor = '0;
    logic [3:0] block = '0;
    logic [5:0] ram_Q;
    logic [7:0] ram_addr;
    logic [5:0] ram_data;
    logic       ram_wren;
    logic       busy;
    logic       done;
    logic [2:0] lines_cleared;
    logic       cell_dropped;

    logic [5:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = '0;
    logic [5:0] tb_din = '0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         wr_log [1024];

    int checks = 0;
    int errors = 0;

    piece_lock_clear dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .X_anchor      (X_anchor),
        .Y_anchor      (Y_anchor),
        .block         (block),
        .ram_Q         (ram_Q),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .cell_dropped  (cell_dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_din;
        else if (ram_wren) mem[ram_addr] <= ram_data;
        ram_Q <= mem[ram_addr];
        if (ram_wren) begin
            wr_log[wr_cnt % 1024] <= int'(ram_addr);
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pat(input int r, input int c);
        return (c == 0) ? 0 : ((r + c) % 7) + 1;
    endfunction

    task automatic write_cell(input int a, input int v);
        tb_we   = 1'b1;
        tb_addr = a[7:0];
        tb_din  = v[5:0];
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic clear_board();
        for (int a = 0; a < 256; a++) write_cell(a, 0);
    endtask

    task automatic fill_row_except(input int r, input int c0, input int c1, input int v);
        for (int c = 0; c < 10; c++)
            if (c != c0 && c != c1) write_cell(r * 10 + c, v);
    endtask

    function automatic int row_sum(input int r);
        int s = 0;
        for (int c = 0; c < 10; c++) s += int'(mem[r * 10 + c]);
        return s;
    endfunction

    task automatic pulse_start(input int x, input int y, input int b);
        X_anchor = x[4:0];
        Y_anchor = y[5:0];
        block    = b[3:0];
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, int'(done), 1);
        @(negedge clk);
    endtask

    task automatic run_lock(input string tag, input int x, input int y, input int b);
        pulse_start(x, y, b);
        check({tag, "_busy"}, int'(busy), 1);
        wait_done(tag);
    endtask

    initial begin
        int base, d0, n;

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wren", int'(ram_wren), 0);
        check("rst_addr", int'(ram_addr), 0);
        check("rst_data", int'(ram_data), 0);
        check("rst_lines", int'(lines_cleared), 0);
        check("rst_drop", int'(cell_dropped), 0);
        resetn = 1'b1;
        @(negedge clk);

        // O-piece on an empty board
        clear_board();
        base = wr_cnt; d0 = done_cnt;
        run_lock("t1", 4, 22, 1);
        check("t1_writes", wr_cnt - base, 4);
        check("t1_a0", wr_log[(base + 0) % 1024], 224);
        check("t1_a1", wr_log[(base + 1) % 1024], 225);
        check("t1_a2", wr_log[(base + 2) % 1024], 234);
        check("t1_a3", wr_log[(base + 3) % 1024], 235);
        check("t1_cell", int'(mem[235]), 2);
        check("t1_lines", int'(lines_cleared), 0);
        check("t1_drop", int'(cell_dropped), 0);
        check("t1_donecnt", done_cnt - d0, 1);
        $display("t1 O-piece empty board: writes=%0d lines=%0d", wr_cnt - base, lines_cleared);

        // single line clear
        clear_board();
        fill_row_except(23, 4, 5, 5);
        base = wr_cnt;
        run_lock("t2", 4, 22, 1);
        check("t2_lines", int'(lines_cleared), 1);
        check("t2_writes", wr_cnt - base, 244);
        check("t2_c234", int'(mem[234]), 2);
        check("t2_c235", int'(mem[235]), 2);
        check("t2_c230", int'(mem[230]), 0);
        check("t2_c239", int'(mem[239]), 0);
        check("t2_row22", row_sum(22), 0);
        check("t2_row0", row_sum(0), 0);
        $display("t2 single clear: writes=%0d lines=%0d", wr_cnt - base, lines_cleared);

        // tetris with vertical I
        clear_board();
        for (int r = 20; r < 24; r++) fill_row_except(r, 9, 9, 5);
        for (int r = 16; r < 20; r++)
            for (int c = 0; c < 10; c++) write_cell(r * 10 + c, pat(r, c));
        base = wr_cnt;
        run_lock("t3", 9, 20, 8);
        check("t3_lines", int'(lines_cleared), 4);
        check("t3_writes", wr_cnt - base, 964);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 10; c++)
                check($sformatf("t3_r%0d_c%0d", 20 + k, c), int'(mem[(20 + k) * 10 + c]), pat(16 + k, c));
        check("t3_row19", row_sum(19), 0);
        check("t3_row0", row_sum(0), 0);
        $display("t3 four-line clear: writes=%0d lines=%0d", wr_cnt - base, lines_cleared);

        // T-piece with one cell below the board
        clear_board();
        base = wr_cnt;
        run_lock("t4", 0, 23, 2);
        check("t4_drop", int'(cell_dropped), 1);
        check("t4_writes", wr_cnt - base, 3);
        check("t4_c230", int'(mem[230]), 3);
        check("t4_c231", int'(mem[231]), 3);
        check("t4_c232", int'(mem[232]), 3);
        check("t4_c241", int'(mem[241]), 0);
        check("t4_lines", int'(lines_cleared), 0);
        $display("t4 dropped cell: writes=%0d dropped=%0d", wr_cnt - base, cell_dropped);

        // second start while busy
        clear_board();
        base = wr_cnt; d0 = done_cnt;
        pulse_start(4, 22, 1);
        repeat (3) @(negedge clk);
        pulse_start(0, 0, 2);
        wait_done("t5");
        repeat (60) @(negedge clk);
        check("t5_donecnt", done_cnt - d0, 1);
        check("t5_writes", wr_cnt - base, 4);
        check("t5_c0", int'(mem[0]), 0);
        check("t5_c224", int'(mem[224]), 2);
        check("t5_lines", int'(lines_cleared), 0);
        check("t5_busy", int'(busy), 0);
        $display("t5 start while busy: dones=%0d writes=%0d", done_cnt - d0, wr_cnt - base);

        // reset in the middle of a shift
        clear_board();
        fill_row_except(23, 4, 5, 5);
        base = wr_cnt;
        pulse_start(4, 22, 1);
        n = 0;
        while (wr_cnt - base < 30 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6_inshift", int'(wr_cnt - base >= 30), 1);
        resetn = 1'b0;
        @(negedge clk);
        check("t6_busy", int'(busy), 0);
        check("t6_wren", int'(ram_wren), 0);
        check("t6_done", int'(done), 0);
        resetn = 1'b1;
        @(negedge clk);
        clear_board();
        base = wr_cnt; d0 = done_cnt;
        run_lock("t6r", 4, 22, 1);
        check("t6r_writes", wr_cnt - base, 4);
        check("t6r_lines", int'(lines_cleared), 0);
        check("t6r_donecnt", done_cnt - d0, 1);
        $display("t6 reset mid-shift then relock: writes=%0d lines=%0d", wr_cnt - base, lines_cleared);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
